// File: rtl/program_loader.sv
// Byte-stream bootloader: length-prefixed stream -> big-endian 32-bit words written to program memory.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int          ADR_W    = 16,
    parameter logic [31:0] BASE_ADR = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [0:7]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [0:31] wr_adr,
    output logic [0:31] wr_data,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_len;
    logic [15:0]        r_cnt;
    logic [ADR_W-1:0]   r_idx;
    logic [1:0]         r_bcnt;
    logic [23:0]        r_shift;
    logic [0:31]        r_adr;
    logic [0:31]        r_wdata;
    logic               r_error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]         r_chk;
`endif

    logic               w_take;
    logic               w_last;
    logic [15:0]        w_len_rx;
    logic [ADR_W-1:0]   w_adr_sum;

    // A byte offered during abort is never consumed by the datapath.
    assign w_take    = in_valid && !abort;
    assign w_last    = (r_cnt == r_len - 16'd1);
    assign w_len_rx  = {r_len[15:8], in_data};
    assign w_adr_sum = ADR_W'(BASE_ADR) + r_idx;

    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign cpu_hold = busy;
    assign done     = (r_state == S_DONE);
    assign error    = r_error;
    assign wr_adr   = r_adr;
    assign wr_data  = r_wdata;

    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK:                      in_ready = 1'b1;
`endif
            default:                    in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wr_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_take) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_take) w_state_nxt = (w_len_rx == 16'd0) ? S_TAIL : S_DATA;
            end
            S_DATA: begin
                if (w_take && r_bcnt == 2'd3) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                wr_en       = !abort;
                w_state_nxt = w_last ? S_TAIL : S_DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_take) w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (abort && busy) w_state_nxt = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_error <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_chk   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_len   <= '0;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_bcnt  <= '0;
                        r_error <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_chk   <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (w_take) begin
                        r_len[15:8] <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_chk       <= r_chk ^ in_data;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (w_take) begin
                        r_len[7:0] <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_chk      <= r_chk ^ in_data;
`endif
                    end
                end
                S_DATA: begin
                    if (w_take) begin
                        r_shift <= {r_shift[15:0], in_data};
                        r_bcnt  <= r_bcnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_chk   <= r_chk ^ in_data;
`endif
                        // Output word/address only change here, so they stay stable outside WRITE.
                        if (r_bcnt == 2'd3) begin
                            r_wdata <= {r_shift, in_data};
                            r_adr   <= 32'(w_adr_sum);
                        end
                    end
                end
                S_WRITE: begin
                    if (!abort) begin
                        r_idx <= r_idx + ADR_W'(1);
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_take && (in_data != r_chk)) r_error <= 1'b1;
                end
`endif
                default: begin
                end
            endcase
            if (abort && busy) r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: hand-computed vectors for basic load, stalls, empty load,
// abort, checksum (when PROGRAM_LOADER_CHECKSUM_EN is defined) and reset during a load.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_adr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;

    program_loader #(.ADR_W(16), .BASE_ADR(32'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_adr   (wr_adr),
        .wr_data  (wr_data),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write/done log captured mid-cycle
    int          wr_count = 0;
    int          done_count = 0;
    logic [31:0] log_adr [0:63];
    logic [31:0] log_dat [0:63];

    always @(negedge clk) begin
        if (wr_en) begin
            log_adr[wr_count[5:0]] <= wr_adr;
            log_dat[wr_count[5:0]] <= wr_data;
            wr_count <= wr_count + 1;
        end
        if (done) done_count <= done_count + 1;
    end

    function automatic logic [31:0] get_adr(input int i);
        return log_adr[i[5:0]];
    endfunction

    function automatic logic [31:0] get_dat(input int i);
        return log_dat[i[5:0]];
    endfunction

    logic [7:0] tb_xor;

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check_eq("in_ready timeout", 32'(in_ready), 32'd1);
        tb_xor = tb_xor ^ b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w, input bit slow);
        for (int k = 3; k >= 0; k--) begin
            send_byte(w[8*k +: 8]);
            if (slow) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic start_load();
        @(posedge clk);
        #1;
        start  = 1'b1;
        tb_xor = 8'h00;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic finish_load();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(tb_xor);
`endif
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            @(negedge clk);
        end
        check_eq(tag, 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int base;
    int dbase;

    initial begin
        // Reset state
        #12;
        check_eq("reset ctrl outs", 32'({busy, cpu_hold, in_ready, wr_en, done, error}), 32'd0);
        check_eq("reset wr_adr", wr_adr, 32'd0);
        check_eq("reset wr_data", wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: one word, streaming
        base  = wr_count;
        dbase = done_count;
        start_load();
        check_eq("t1 busy", 32'(busy), 32'd1);
        check_eq("t1 cpu_hold", 32'(cpu_hold), 32'd1);
        send_len(16'd1);
        send_word(32'hDEADBEEF, 1'b0);
        finish_load();
        wait_done("t1 done");
        check_eq("t1 wr count", 32'(wr_count - base), 32'd1);
        check_eq("t1 wr_adr", get_adr(base), 32'd0);
        check_eq("t1 wr_data", get_dat(base), 32'hDEADBEEF);
        check_eq("t1 error", 32'(error), 32'd0);
        check_eq("t1 busy after", 32'(busy), 32'd0);
        check_eq("t1 done pulses", 32'(done_count - dbase), 32'd1);

        // T2: three words with in_valid toggling
        base = wr_count;
        start_load();
        send_byte(8'h00); @(posedge clk); #1;
        send_byte(8'h03); @(posedge clk); #1;
        send_word(32'h01234567, 1'b1);
        send_word(32'h89ABCDEF, 1'b1);
        send_word(32'h0BADF00D, 1'b1);
        finish_load();
        wait_done("t2 done");
        check_eq("t2 wr count", 32'(wr_count - base), 32'd3);
        check_eq("t2 adr0", get_adr(base), 32'd0);
        check_eq("t2 adr1", get_adr(base + 1), 32'd1);
        check_eq("t2 adr2", get_adr(base + 2), 32'd2);
        check_eq("t2 dat0", get_dat(base), 32'h01234567);
        check_eq("t2 dat1", get_dat(base + 1), 32'h89ABCDEF);
        check_eq("t2 dat2", get_dat(base + 2), 32'h0BADF00D);
        check_eq("t2 error", 32'(error), 32'd0);

        // T3: empty program
        base = wr_count;
        start_load();
        send_len(16'd0);
        finish_load();
        check_eq("t3 done", 32'(done), 32'd1);
        check_eq("t3 busy", 32'({busy, cpu_hold}), 32'd0);
        @(posedge clk);
        #1;
        check_eq("t3 done drops", 32'(done), 32'd0);
        check_eq("t3 wr count", 32'(wr_count - base), 32'd0);

        // T4: abort in the middle of word 1
        base = wr_count;
        start_load();
        send_len(16'd2);
        send_word(32'hA5A55A5A, 1'b0);
        send_byte(8'h12);
        send_byte(8'h34);
        abort = 1'b1;
        @(negedge clk);
        check_eq("t4 wr_en on abort", 32'(wr_en), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq("t4 done", 32'(done), 32'd1);
        check_eq("t4 error", 32'(error), 32'd1);
        check_eq("t4 busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4 error sticky", 32'(error), 32'd1);
        check_eq("t4 wr count", 32'(wr_count - base), 32'd1);
        check_eq("t4 adr0", get_adr(base), 32'd0);
        check_eq("t4 dat0", get_dat(base), 32'hA5A55A5A);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("t4 start+abort idle", 32'({busy, error}), 32'd1);
        base = wr_count;
        start_load();
        check_eq("t4 error cleared", 32'(error), 32'd0);
        send_len(16'd1);
        send_word(32'h11223344, 1'b0);
        finish_load();
        wait_done("t4 reload done");
        check_eq("t4 reload error", 32'(error), 32'd0);
        check_eq("t4 reload count", 32'(wr_count - base), 32'd1);
        check_eq("t4 reload adr", get_adr(base), 32'd0);
        check_eq("t4 reload dat", get_dat(base), 32'h11223344);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // T5: checksum good then bad
        start_load();
        send_len(16'd1);
        send_word(32'h01020304, 1'b0);
        send_byte(8'h05);
        wait_done("t5 good done");
        check_eq("t5 good error", 32'(error), 32'd0);
        start_load();
        send_len(16'd1);
        send_word(32'h01020304, 1'b0);
        send_byte(8'h06);
        wait_done("t5 bad done");
        check_eq("t5 bad error", 32'(error), 32'd1);
`endif

        // T6: reset in the middle of DATA
        base = wr_count;
        start_load();
        send_len(16'd2);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rst_n = 1'b0;
        #1;
        check_eq("t6 async reset outs", 32'({busy, cpu_hold, in_ready, wr_en}), 32'd0);
        check_eq("t6 reset done/error", 32'({done, error}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t6 no write", 32'(wr_count - base), 32'd0);
        start_load();
        send_len(16'd1);
        send_word(32'hCAFEF00D, 1'b0);
        finish_load();
        wait_done("t6 reload done");
        check_eq("t6 reload count", 32'(wr_count - base), 32'd1);
        check_eq("t6 reload adr", get_adr(base), 32'd0);
        check_eq("t6 reload dat", get_dat(base), 32'hCAFEF00D);
        check_eq("t6 reload error", 32'(error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
